// File: rtl/hmac_sha_pad_ctrl.sv
// hmac_sha_pad_ctrl: forwards HMAC message words to the SHA-256 engine and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length in 16-word blocks.
module hmac_sha_pad_ctrl #(
    parameter int BlockWords = 16,
    parameter int LenBits    = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hash_start_i,
    input  logic               hash_process_i,
    input  logic               fifo_rvalid_i,
    input  logic [35:0]        fifo_rdata_i,
    output logic               fifo_rready_o,
    output logic               shaf_rvalid_o,
    output logic [31:0]        shaf_rdata_o,
    input  logic               shaf_rready_i,
    output logic [LenBits-1:0] msg_length_o,
    output logic               idle_o,
    output logic               done_o,
    output logic               err_o
);
    localparam int CntW = $clog2(BlockWords);
    localparam logic [CntW-1:0] LenCnt = CntW'(BlockWords - 2);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] PAD80 = 3'd2;
    localparam logic [2:0] PAD00 = 3'd3;
    localparam logic [2:0] LENHI = 3'd4;
    localparam logic [2:0] LENLO = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [LenBits-1:0] len_q, len_d, add;
    logic               pend_q, pend_d, done_q, done_d, err_q, err_d;
    logic [31:0]        data, pad_word;
    logic [3:0]         mask;
    logic               full, part, bad, xfer;

    assign data  = fifo_rdata_i[35:4];
    assign mask  = fifo_rdata_i[3:0];
    assign full  = mask == 4'b1111;
    assign part  = mask == 4'b1110 || mask == 4'b1100 || mask == 4'b1000;
    assign bad   = !full && !part;
    assign add   = full ? LenBits'(32) : mask == 4'b1110 ? LenBits'(24) :
                   mask == 4'b1100 ? LenBits'(16) : LenBits'(8);
    // A short final word carries the 0x80 marker in its first unused byte.
    assign pad_word = mask == 4'b1110 ? {data[31:8], 8'h80} :
                      mask == 4'b1100 ? {data[31:16], 16'h8000} : {data[31:24], 24'h80_0000};
    assign xfer  = shaf_rvalid_o && shaf_rready_i;

    assign msg_length_o = len_q;
    assign idle_o       = state_q == IDLE;
    assign done_o       = done_q;
    assign err_o        = err_q;

    always_comb begin
        fifo_rready_o = 1'b0;
        shaf_rvalid_o = 1'b0;
        shaf_rdata_o  = '0;
        case (state_q)
            RECV: begin
                shaf_rvalid_o = fifo_rvalid_i && !bad;
                fifo_rready_o = bad || shaf_rready_i;
                shaf_rdata_o  = full ? data : pad_word;
            end
            PAD80: begin
                shaf_rvalid_o = 1'b1;
                shaf_rdata_o  = 32'h8000_0000;
            end
            PAD00: shaf_rvalid_o = cnt_q != LenCnt;
            LENHI: begin
                shaf_rvalid_o = 1'b1;
                shaf_rdata_o  = len_q[LenBits-1 -: 32];
            end
            LENLO: begin
                shaf_rvalid_o = 1'b1;
                shaf_rdata_o  = len_q[31:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = xfer ? cnt_q + CntW'(1) : cnt_q;
        len_d   = len_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        err_d   = hash_start_i && state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (hash_start_i) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    len_d   = '0;
                    pend_d  = hash_process_i;
                end else if (hash_process_i) begin
                    err_d = 1'b1;
                end
            end
            RECV: begin
                if (hash_process_i) pend_d = 1'b1;
                if (fifo_rvalid_i) begin
                    if (bad) err_d = 1'b1;
                    else if (xfer) begin
                        len_d = len_q + add;
                        if (part) state_d = cnt_d == LenCnt ? LENHI : PAD00;
                    end
                end else if (pend_q) begin
                    state_d = PAD80;
                end
            end
            PAD80: if (xfer) state_d = cnt_d == LenCnt ? LENHI : PAD00;
            PAD00: if (cnt_q == LenCnt) state_d = LENHI;
            LENHI: if (xfer) state_d = LENLO;
            LENLO: begin
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_hmac_sha_pad_ctrl.sv
// tb_hmac_sha_pad_ctrl: directed messages against a byte-level SHA-256 padding model.
module tb_hmac_sha_pad_ctrl;
    logic        clk_i = 1'b0, rst_ni = 1'b1;
    logic        hash_start_i = 1'b0, hash_process_i = 1'b0;
    logic        fifo_rvalid_i = 1'b0, shaf_rready_i = 1'b1;
    logic [35:0] fifo_rdata_i = '0;
    logic        fifo_rready_o, shaf_rvalid_o, idle_o, done_o, err_o;
    logic [31:0] shaf_rdata_o;
    logic [63:0] msg_length_o;

    always #5 clk_i = ~clk_i;

    hmac_sha_pad_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .hash_start_i(hash_start_i), .hash_process_i(hash_process_i),
        .fifo_rvalid_i(fifo_rvalid_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rready_o(fifo_rready_o),
        .shaf_rvalid_o(shaf_rvalid_o), .shaf_rdata_o(shaf_rdata_o), .shaf_rready_i(shaf_rready_i),
        .msg_length_o(msg_length_o), .idle_o(idle_o), .done_o(done_o), .err_o(err_o)
    );

    int          checks = 0, failures = 0;
    int          errs, cyc, done_cyc, last_x;
    logic [35:0] msg[$], fq[$];
    logic [31:0] outq[$], expq[$];
    bit          hold_v = 1'b0;
    logic [31:0] hold_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return i < outq.size() ? outq[i] : 32'hxxxx_xxxx;
    endfunction

    // Standard SHA-256 padding over the accepted message bytes.
    task automatic build_exp();
        logic [7:0]  b[$];
        logic [63:0] bits;
        logic [3:0]  m;
        expq.delete();
        foreach (msg[i]) begin
            m = msg[i][3:0];
            if (m == 4'b1111 || m == 4'b1110 || m == 4'b1100 || m == 4'b1000)
                for (int k = 0; k < 4; k++) if (m[3-k]) b.push_back(msg[i][35-8*k -: 8]);
        end
        bits = 64'(b.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
        for (int i = 0; i < b.size(); i += 4) expq.push_back({b[i], b[i+1], b[i+2], b[i+3]});
    endtask

    task automatic cycle(input bit stall);
        bit pop;
        fifo_rvalid_i = fq.size() > 0;
        fifo_rdata_i  = fq.size() > 0 ? fq[0] : '0;
        @(negedge clk_i);
        if (hold_v) check("hold", {31'd0, shaf_rvalid_o, shaf_rdata_o}, {31'd0, 1'b1, hold_d});
        hold_v = shaf_rvalid_o && !shaf_rready_i;
        hold_d = shaf_rdata_o;
        if (shaf_rvalid_o && shaf_rready_i) begin
            outq.push_back(shaf_rdata_o);
            last_x = cyc;
        end
        pop = fifo_rvalid_i && fifo_rready_o;
        if (err_o) errs++;
        if (done_o && done_cyc < 0) done_cyc = cyc;
        cyc++;
        @(posedge clk_i);
        #1;
        if (pop) void'(fq.pop_front());
        hash_start_i   = 1'b0;
        hash_process_i = 1'b0;
        shaf_rready_i  = stall ? $urandom_range(0, 2) != 0 : 1'b1;
    endtask

    task automatic run_msg(input bit stall, input int start_at, input logic [63:0] exp_len,
                           input int exp_err, input string tag);
        bit fired = 1'b0;
        fq = msg;
        build_exp();
        outq.delete();
        errs = 0; cyc = 0; done_cyc = -1; last_x = -1;
        hash_start_i = 1'b1;
        cycle(stall);
        hash_process_i = 1'b1;
        cycle(stall);
        for (int n = 0; n < 3000 && done_cyc < 0; n++) begin
            if (outq.size() == start_at && !fired) begin
                hash_start_i = 1'b1;
                fired = 1'b1;
            end
            cycle(stall);
        end
        repeat (2) cycle(stall);
        check({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check({tag, " done_timing"}, 64'(done_cyc), 64'(last_x + 1));
        check({tag, " len"}, msg_length_o, exp_len);
        check({tag, " errs"}, 64'(errs), 64'(exp_err));
        check({tag, " fifo_left"}, 64'(fq.size()), 64'd0);
        check({tag, " idle"}, 64'(idle_o), 64'd1);
        check({tag, " nwords"}, 64'(outq.size()), 64'(expq.size()));
        foreach (expq[i]) check($sformatf("%s w%0d", tag, i), 64'(word(i)), 64'(expq[i]));
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #2;
        check("rst rready", 64'(fifo_rready_o), 64'd0);
        check("rst rvalid", 64'(shaf_rvalid_o), 64'd0);
        check("rst rdata", 64'(shaf_rdata_o), 64'd0);
        check("rst idle", 64'(idle_o), 64'd1);
        check("rst done", 64'(done_o), 64'd0);
        check("rst err", 64'(err_o), 64'd0);
        check("rst len", msg_length_o, 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        errs = 0; outq.delete();
        hash_process_i = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        check("idle_proc err", 64'(errs), 64'd1);
        check("idle_proc idle", 64'(idle_o), 64'd1);
        check("idle_proc words", 64'(outq.size()), 64'd0);

        msg.delete();
        run_msg(1'b0, -1, 64'd0, 0, "empty");
        check("empty first", 64'(word(0)), 64'h8000_0000);
        check("empty last", 64'(word(15)), 64'h0);

        msg = '{{32'h6162_6300, 4'b1110}};
        run_msg(1'b0, -1, 64'd24, 0, "abc");
        check("abc first", 64'(word(0)), 64'h6162_6380);
        check("abc last", 64'(word(15)), 64'h18);

        msg.delete();
        for (int i = 0; i < 14; i++) msg.push_back({32'(32'h0100_0000 + i), 4'hF});
        run_msg(1'b0, -1, 64'd448, 0, "full14");
        check("full14 w14", 64'(word(14)), 64'h8000_0000);
        check("full14 w15", 64'(word(15)), 64'h0);
        check("full14 w31", 64'(word(31)), 64'h1C0);

        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back({32'(32'hA5A5_0000 + i * 3), 4'hF});
        run_msg(1'b1, -1, 64'd640, 0, "stall20");
        check("stall20 w31", 64'(word(31)), 64'h280);

        msg = '{{32'h1111_2222, 4'hF}, {32'hDEAD_BEEF, 4'b0101}, {32'h3333_4444, 4'hF}};
        run_msg(1'b0, -1, 64'd64, 1, "badmask");
        check("badmask w1", 64'(word(1)), 64'h3333_4444);

        msg.delete();
        run_msg(1'b0, 3, 64'd0, 1, "start_pad00");

        fq.delete(); outq.delete(); errs = 0; cyc = 0; done_cyc = -1;
        hash_start_i = 1'b1;
        cycle(1'b0);
        hash_process_i = 1'b1;
        cycle(1'b0);
        for (int n = 0; n < 50 && outq.size() < 3; n++) cycle(1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst rvalid", 64'(shaf_rvalid_o), 64'd0);
        check("mid_rst rdata", 64'(shaf_rdata_o), 64'd0);
        check("mid_rst rready", 64'(fifo_rready_o), 64'd0);
        check("mid_rst idle", 64'(idle_o), 64'd1);
        check("mid_rst len", msg_length_o, 64'd0);
        @(negedge clk_i);
        check("mid_rst held", 64'({shaf_rvalid_o, done_o}), 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        hold_v = 1'b0;
        msg.delete();
        run_msg(1'b0, -1, 64'd0, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
